// File: rtl/dili_ntt_seq.sv
// Address/zeta sequencer for the Dilithium NTT butterfly datapath: 8 layers x 128 butterflies.
// Define DILI_NTT_INTT_EN to add the inverse (Gentleman-Sande) ordering via inv_i / zeta_neg_o.
module dili_ntt_seq #(
  parameter int ADDR_W = 8,
  parameter int BU_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stall_i,
`ifdef DILI_NTT_INTT_EN
  input  logic              inv_i,
  output logic              zeta_neg_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_even_o,
  output logic [ADDR_W-1:0] rd_addr_odd_o,
  output logic [ADDR_W-1:0] zeta_idx_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_even_o,
  output logic [ADDR_W-1:0] wr_addr_odd_o,
  output logic [2:0]        layer_o
);
  localparam int          NW   = ADDR_W - 1;
  localparam logic [2:0]  LMAX = 3'(ADDR_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      l_q, l_d;
  logic [NW-1:0]   n_q, n_d;
  logic [2:0]      dcnt_q, dcnt_d;
  logic            inv_q, inv_d;
  logic            start_inv, last_layer;

`ifdef DILI_NTT_INTT_EN
  assign start_inv = inv_i;
`else
  assign start_inv = 1'b0;
`endif

  assign last_layer = inv_q ? (l_q == 3'd0) : (l_q == LMAX);

  // Butterfly geometry from (l, n): len = N/2 >> l, g = group, o = offset in group
  logic [2:0]        sh;
  logic [ADDR_W-1:0] len, gl, j, k_fwd, k_inv;
  logic [NW-1:0]     g, o;

  always_comb begin
    sh    = LMAX - l_q;
    len   = ADDR_W'(1) << sh;
    g     = n_q >> sh;
    o     = n_q & (len[NW-1:0] - NW'(1));
    gl    = {1'b0, g} << sh;
    j     = {gl[ADDR_W-2:0], 1'b0} | {1'b0, o};
    k_fwd = (ADDR_W'(1) << l_q) + {1'b0, g};
    k_inv = (ADDR_W'(2) << l_q) - ADDR_W'(1) - {1'b0, g};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      l_q     <= '0;
      n_q     <= '0;
      dcnt_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      n_q     <= n_d;
      dcnt_q  <= dcnt_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    n_d     = n_q;
    dcnt_d  = dcnt_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        l_d     = start_inv ? LMAX : 3'd0;
        n_d     = '0;
        dcnt_d  = '0;
        inv_d   = start_inv;
      end
      RUN: if (!stall_i) begin
        n_d = n_q + NW'(1);
        if (n_q == '1) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      // n has already wrapped to 0; only the layer moves on
      DRAIN: if (!stall_i) begin
        if (dcnt_q == 3'(BU_LAT - 1)) begin
          state_d = last_layer ? DONE : RUN;
          if (!last_layer) l_d = inv_q ? l_q - 3'd1 : l_q + 3'd1;
        end else begin
          dcnt_d = dcnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        l_d     = '0;
        inv_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q == RUN) || (state_q == DRAIN);
    done_o         = (state_q == DONE);
    rd_en_o        = (state_q == RUN) && !stall_i;
    rd_addr_even_o = (state_q == RUN) ? j : '0;
    rd_addr_odd_o  = (state_q == RUN) ? j + len : '0;
    zeta_idx_o     = (state_q == RUN) ? (inv_q ? k_inv : k_fwd) : '0;
    layer_o        = l_q;
  end

`ifdef DILI_NTT_INTT_EN
  assign zeta_neg_o = rd_en_o && inv_q;
`endif

  // Write-back delay line; bubbles shift through as valid=0
  logic [BU_LAT-1:0]             vld_pipe_q;
  logic [BU_LAT-1:0][ADDR_W-1:0] ev_pipe_q, od_pipe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      ev_pipe_q  <= '0;
      od_pipe_q  <= '0;
    end else if (!stall_i) begin
      for (int i = BU_LAT - 1; i > 0; i--) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        ev_pipe_q[i]  <= ev_pipe_q[i-1];
        od_pipe_q[i]  <= od_pipe_q[i-1];
      end
      vld_pipe_q[0] <= rd_en_o;
      ev_pipe_q[0]  <= rd_addr_even_o;
      od_pipe_q[0]  <= rd_addr_odd_o;
    end
  end

  assign wr_en_o        = vld_pipe_q[BU_LAT-1] && !stall_i;
  assign wr_addr_even_o = ev_pipe_q[BU_LAT-1];
  assign wr_addr_odd_o  = od_pipe_q[BU_LAT-1];

endmodule
